decoder_bcd_7seg: RTL and testbench

- Registered BCD-to-7-segment decoder for one display digit.
- Converts a 4-bit BCD code `Binario` into a 7-bit segment pattern `Decimal`.
- Includes lamp-test, blanking and leading-zero ripple-blanking controls, so several instances can be chained into a multi-digit display.
- Sits between the numeric datapath and the display pin drivers.

---
 rtl/decoder_bcd_7seg_pkg.sv | 41 ++++
 rtl/decoder_bcd_7seg_glyph_lut.sv | 35 +++
 rtl/decoder_bcd_7seg.sv | 54 +++++
 tb/tb_decoder_bcd_7seg.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/decoder_bcd_7seg_pkg.sv
// Shared types and glyph constants for the BCD-to-7-segment decoder.
// Segment bit order: bit0 = a ... bit6 = g, active-high.
package decoder_bcd_7seg_pkg;

    localparam int unsigned CODE_W = 4;
    localparam int unsigned SEG_W  = 7;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t GLYPH_0 = 7'h3F;
    localparam seg_t GLYPH_1 = 7'h06;
    localparam seg_t GLYPH_2 = 7'h5B;
    localparam seg_t GLYPH_3 = 7'h4F;
    localparam seg_t GLYPH_4 = 7'h66;
    localparam seg_t GLYPH_5 = 7'h6D;
    localparam seg_t GLYPH_6 = 7'h7D;
    localparam seg_t GLYPH_7 = 7'h07;
    localparam seg_t GLYPH_8 = 7'h7F;
    localparam seg_t GLYPH_9 = 7'h6F;

    localparam seg_t GLYPH_HEX_A = 7'h77;
    localparam seg_t GLYPH_HEX_B = 7'h7C;
    localparam seg_t GLYPH_HEX_C = 7'h39;
    localparam seg_t GLYPH_HEX_D = 7'h5E;
    localparam seg_t GLYPH_HEX_E = 7'h79;
    localparam seg_t GLYPH_HEX_F = 7'h71;

    // Dash lights only the middle bar.
    localparam seg_t GLYPH_DASH    = SEG_W'(1) << SEG_G;
    localparam seg_t GLYPH_ALL_ON  = 7'h7F;
    localparam seg_t GLYPH_ALL_OFF = 7'h00;

endpackage

// File: rtl/decoder_bcd_7seg_glyph_lut.sv
// Combinational code-to-glyph table, active-high.
// HEX_DIGITS_EN: codes 10-15 show A-F instead of a dash.
module seg_glyph_lut
    import decoder_bcd_7seg_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output seg_t              glyph_c
);

    always_comb begin
        glyph_c = GLYPH_DASH;
        case (code)
            4'd0:    glyph_c = GLYPH_0;
            4'd1:    glyph_c = GLYPH_1;
            4'd2:    glyph_c = GLYPH_2;
            4'd3:    glyph_c = GLYPH_3;
            4'd4:    glyph_c = GLYPH_4;
            4'd5:    glyph_c = GLYPH_5;
            4'd6:    glyph_c = GLYPH_6;
            4'd7:    glyph_c = GLYPH_7;
            4'd8:    glyph_c = GLYPH_8;
            4'd9:    glyph_c = GLYPH_9;
`ifdef HEX_DIGITS_EN
            4'd10:   glyph_c = GLYPH_HEX_A;
            4'd11:   glyph_c = GLYPH_HEX_B;
            4'd12:   glyph_c = GLYPH_HEX_C;
            4'd13:   glyph_c = GLYPH_HEX_D;
            4'd14:   glyph_c = GLYPH_HEX_E;
            4'd15:   glyph_c = GLYPH_HEX_F;
`endif
            default: glyph_c = GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/decoder_bcd_7seg.sv
// Registered BCD-to-7-segment digit decoder with lamp test, blanking and
// ripple blanking. HEX_DIGITS_EN selects hex glyphs for codes 10-15.
module decoder_bcd_7seg
    import decoder_bcd_7seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] Binario,
    input  logic              lamp_test,
    input  logic              blank,
    input  logic              rbi,
    output logic [SEG_W-1:0]  Decimal,
    output logic              rbo
);

    seg_t glyph_c;
    seg_t seg_next_c;
    logic rbo_next_c;
    seg_t seg_pol_c;

    seg_glyph_lut u_lut (
        .code    (Binario),
        .glyph_c (glyph_c)
    );

    // Control priority: lamp test, forced blank, leading-zero suppression, decode.
    always_comb begin
        seg_next_c = glyph_c;
        rbo_next_c = 1'b0;
        if (lamp_test) begin
            seg_next_c = GLYPH_ALL_ON;
        end else if (blank) begin
            seg_next_c = GLYPH_ALL_OFF;
        end else if (rbi && (Binario == CODE_W'(0))) begin
            seg_next_c = GLYPH_ALL_OFF;
            rbo_next_c = 1'b1;
        end
    end

    assign seg_pol_c = ACTIVE_LOW ? ~seg_next_c : seg_next_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Decimal <= ACTIVE_LOW ? ~GLYPH_ALL_OFF : GLYPH_ALL_OFF;
            rbo     <= 1'b0;
        end else begin
            Decimal <= seg_pol_c;
            rbo     <= rbo_next_c;
        end
    end

endmodule

// File: tb/tb_decoder_bcd_7seg.sv
// Self-checking bench for decoder_bcd_7seg: vector table, hand sequences and
// random stimulus against a reference model; both polarities run side by side.
module tb_decoder_bcd_7seg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] Binario;
    logic       lamp_test;
    logic       blank;
    logic       rbi;
    logic [6:0] dec_hi;
    logic       rbo_hi;
    logic [6:0] dec_lo;
    logic       rbo_lo;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    decoder_bcd_7seg #(.ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .Binario(Binario), .lamp_test(lamp_test),
        .blank(blank), .rbi(rbi), .Decimal(dec_hi), .rbo(rbo_hi)
    );

    decoder_bcd_7seg #(.ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk(clk), .rst_n(rst_n), .Binario(Binario), .lamp_test(lamp_test),
        .blank(blank), .rbi(rbi), .Decimal(dec_lo), .rbo(rbo_lo)
    );

    // Reference model: returns {rbo, segments} active-high.
    function automatic logic [7:0] ref_model(input bit rst, input int code,
                                             input bit lt, input bit bl, input bit ri);
        int digits [10] = '{63, 6, 91, 79, 102, 109, 125, 7, 127, 111};
        int hexes  [6]  = '{8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
        int seg;
        if (!rst)                   return 8'h00;
        if (lt)                     return 8'h7F;
        if (bl)                     return 8'h00;
        if (ri && code == 0)        return 8'h80;
        if (code < 10)              seg = digits[code];
        else begin
`ifdef HEX_DIGITS_EN
            seg = hexes[code - 10];
`else
            seg = 8'h40;
`endif
        end
        return 8'(seg);
    endfunction

    task automatic check(input string name, input logic [6:0] exp, input logic exp_rbo);
        n_total++;
        if (dec_hi === exp && rbo_hi === exp_rbo) n_pass++;
        else $display("FAIL %s (active-high): got seg=%h rbo=%b, want seg=%h rbo=%b",
                      name, dec_hi, rbo_hi, exp, exp_rbo);
        n_total++;
        if (dec_lo === ~exp && rbo_lo === exp_rbo) n_pass++;
        else $display("FAIL %s (active-low): got seg=%h rbo=%b, want seg=%h rbo=%b",
                      name, dec_lo, rbo_lo, ~exp, exp_rbo);
    endtask

    // Drive inputs at the falling edge, then sample just after the next rising edge.
    task automatic step(input bit r, input logic [3:0] c, input bit lt, input bit bl,
                        input bit ri);
        @(negedge clk);
        rst_n = r; Binario = c; lamp_test = lt; blank = bl; rbi = ri;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string      name;
        logic [3:0] code;
        bit         lt;
        bit         bl;
        bit         ri;
        logic [6:0] exp;
        logic       exp_rbo;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [7:0] m;
        bit r, lt, bl, ri;
        logic [3:0] c;

        // Table of expected values taken directly from the decode rules.
        vecs.push_back('{"sweep0", 4'd0, 0, 0, 0, 7'd63,  1'b0});
        vecs.push_back('{"sweep1", 4'd1, 0, 0, 0, 7'd6,   1'b0});
        vecs.push_back('{"sweep2", 4'd2, 0, 0, 0, 7'd91,  1'b0});
        vecs.push_back('{"sweep3", 4'd3, 0, 0, 0, 7'd79,  1'b0});
        vecs.push_back('{"sweep4", 4'd4, 0, 0, 0, 7'd102, 1'b0});
        vecs.push_back('{"sweep5", 4'd5, 0, 0, 0, 7'd109, 1'b0});
        vecs.push_back('{"sweep6", 4'd6, 0, 0, 0, 7'd125, 1'b0});
        vecs.push_back('{"sweep7", 4'd7, 0, 0, 0, 7'd7,   1'b0});
        vecs.push_back('{"sweep8", 4'd8, 0, 0, 0, 7'd127, 1'b0});
        vecs.push_back('{"sweep9", 4'd9, 0, 0, 0, 7'd111, 1'b0});
`ifdef HEX_DIGITS_EN
        vecs.push_back('{"code12", 4'd12, 0, 0, 0, 7'h39, 1'b0});
        vecs.push_back('{"code15", 4'd15, 0, 0, 0, 7'h71, 1'b0});
        vecs.push_back('{"code10", 4'd10, 0, 0, 0, 7'h77, 1'b0});
`else
        vecs.push_back('{"code12", 4'd12, 0, 0, 0, 7'h40, 1'b0});
        vecs.push_back('{"code15", 4'd15, 0, 0, 0, 7'h40, 1'b0});
        vecs.push_back('{"code10", 4'd10, 0, 0, 0, 7'h40, 1'b0});
`endif
        vecs.push_back('{"lamp_over_blank", 4'd3, 1, 1, 0, 7'h7F, 1'b0});
        vecs.push_back('{"blank3",          4'd3, 0, 1, 0, 7'h00, 1'b0});
        vecs.push_back('{"rbi_zero",        4'd0, 0, 0, 1, 7'h00, 1'b1});
        vecs.push_back('{"rbi_five",        4'd5, 0, 0, 1, 7'h6D, 1'b0});
        vecs.push_back('{"blank_over_rbi",  4'd0, 0, 1, 1, 7'h00, 1'b0});
        vecs.push_back('{"lamp_over_rbi",   4'd0, 1, 0, 1, 7'h7F, 1'b0});
        vecs.push_back('{"rbi_code10",      4'd10, 0, 0, 1, ref_model(1, 10, 0, 0, 0), 1'b0});

        // Reset held two cycles with code 8 present.
        step(0, 4'd8, 0, 0, 0);
        check("reset_c1", 7'h00, 1'b0);
        step(0, 4'd8, 0, 0, 0);
        check("reset_c2", 7'h00, 1'b0);
        step(1, 4'd8, 0, 0, 0);
        check("after_reset", 7'd127, 1'b0);

        foreach (vecs[i]) begin
            step(1, vecs[i].code, vecs[i].lt, vecs[i].bl, vecs[i].ri);
            check(vecs[i].name, vecs[i].exp, vecs[i].exp_rbo);
        end

        // Mid-stream reset discards the pending value, then decoding resumes.
        step(1, 4'd4, 0, 0, 0);
        check("mid_code4", 7'd102, 1'b0);
        step(1, 4'd5, 0, 0, 0);
        check("mid_code5", 7'd109, 1'b0);
        step(0, 4'd6, 0, 0, 1);
        check("mid_reset", 7'h00, 1'b0);
        step(1, 4'd6, 0, 0, 0);
        check("mid_resume6", 7'd125, 1'b0);

        // Random stimulus against the model.
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(15) != 0);
            c  = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15));
            lt = ($urandom_range(7) == 0);
            bl = ($urandom_range(7) == 0);
            ri = ($urandom_range(1) == 1);
            step(r, c, lt, bl, ri);
            m = ref_model(r, int'(c), lt, bl, ri);
            check("random", m[6:0], m[7]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
